// File: rtl/fb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fb_mem_arbiter
//
// Two-client framebuffer memory arbiter. Client 0 (fill_rect_engine) and
// client 1 (display/readback) issue pixel reads/writes over rts/rtr
// handshakes. The winner is captured in a one-entry issue register that
// drives a single-ported, 1-cycle-latency framebuffer memory. Read data is
// routed back to the client that issued the read.
//
// Optional feature macro:
//   FB_ARB_ROUND_ROBIN_EN  defined   : round-robin on ties (last-granted pointer)
//                          undefined : fixed priority, client 0 wins ties
//
// Ports:
//   clk, rst_                 clock, synchronous active-high reset
//   cX_in_data/addr/wben/op   client X request payload (op: 1 = write, 0 = read)
//   cX_in_rts / cX_out_rtr    client X request handshake (rtr combinational)
//   cX_out_rdata/rvalid       client X read return (rvalid one-cycle pulse)
//   mem_en/addr/wdata/we      memory request (we all-zero for reads)
//   mem_stall                 memory cannot accept the presented request
//   mem_rdata                 memory read data, valid cycle after read accept
// ---------------------------------------------------------------------------
module fb_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_,

    input  logic [DATA_W-1:0]   c0_in_data,
    input  logic [ADDR_W-1:0]   c0_in_addr,
    input  logic [DATA_W/8-1:0] c0_in_wben,
    input  logic                c0_in_op,
    input  logic                c0_in_rts,
    output logic                c0_out_rtr,
    output logic [DATA_W-1:0]   c0_out_rdata,
    output logic                c0_out_rvalid,

    input  logic [DATA_W-1:0]   c1_in_data,
    input  logic [ADDR_W-1:0]   c1_in_addr,
    input  logic [DATA_W/8-1:0] c1_in_wben,
    input  logic                c1_in_op,
    input  logic                c1_in_rts,
    output logic                c1_out_rtr,
    output logic [DATA_W-1:0]   c1_out_rdata,
    output logic                c1_out_rvalid,

    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_we,
    input  logic                mem_stall,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    // issue register
    logic              r_valid;
    logic              r_op;
    logic              r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_wben;

    // one-deep read return tag
    logic              r_ret_valid;
    logic              r_ret_id;

    logic w_accept;
    logic w_can_load;
    logic w_gnt0;
    logic w_gnt1;
    logic w_xfer0;
    logic w_xfer1;
    logic w_xfer;
    logic w_rd_accept;

    assign w_accept    = r_valid && !mem_stall;
    assign w_rd_accept = w_accept && !r_op;
    // Empty, or draining this edge: a new request can slot in behind it.
    assign w_can_load  = !r_valid || !mem_stall;

`ifdef FB_ARB_ROUND_ROBIN_EN
    // r_last = id of the client granted on the most recent transfer.
    logic r_last;

    assign w_gnt1 = c1_in_rts && (!c0_in_rts || !r_last);

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_last <= 1'b1;
        end else if (w_xfer) begin
            r_last <= w_xfer1;
        end
    end
`else
    assign w_gnt1 = c1_in_rts && !c0_in_rts;
`endif

    assign w_gnt0 = c0_in_rts && !w_gnt1;

    assign c0_out_rtr = !rst_ && w_can_load && w_gnt0;
    assign c1_out_rtr = !rst_ && w_can_load && w_gnt1;

    assign w_xfer0 = c0_in_rts && c0_out_rtr;
    assign w_xfer1 = c1_in_rts && c1_out_rtr;
    assign w_xfer  = w_xfer0 || w_xfer1;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_valid     <= 1'b0;
            r_op        <= 1'b0;
            r_id        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wben      <= '0;
            r_ret_valid <= 1'b0;
            r_ret_id    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_id    <= w_xfer1;
                r_op    <= w_xfer1 ? c1_in_op   : c0_in_op;
                r_addr  <= w_xfer1 ? c1_in_addr : c0_in_addr;
                r_wdata <= w_xfer1 ? c1_in_data : c0_in_data;
                r_wben  <= w_xfer1 ? c1_in_wben : c0_in_wben;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            // The tag lives exactly one cycle, matching the memory latency,
            // so back-to-back reads simply overwrite it.
            r_ret_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_ret_id <= r_id;
            end
        end
    end

    // Outputs are forced low while reset is asserted so an in-flight read
    // return or a stale request never leaks out during the reset cycle.
    assign mem_en    = !rst_ && r_valid;
    assign mem_addr  = rst_ ? '0 : r_addr;
    assign mem_wdata = rst_ ? '0 : r_wdata;
    assign mem_we    = (!rst_ && r_op) ? r_wben : '0;

    assign c0_out_rvalid = !rst_ && r_ret_valid && !r_ret_id;
    assign c1_out_rvalid = !rst_ && r_ret_valid &&  r_ret_id;
    assign c0_out_rdata  = c0_out_rvalid ? mem_rdata : '0;
    assign c1_out_rdata  = c1_out_rvalid ? mem_rdata : '0;

endmodule
